// File: rtl/fht_pkg.sv
// Shared types and defaults for the radix-2 FHT butterfly sequencer.
package fht_pkg;

  localparam int unsigned N_LOG2_DEF   = 10;
  localparam int unsigned PIPE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [N_LOG2_DEF-1:0] addr_t;

endpackage

// File: rtl/fht_addr_gen.sv
// Combinational butterfly address generator: (stage, op count) -> data/coef addresses.
module fht_addr_gen import fht_pkg::*; #(
  parameter  int unsigned N_LOG2 = N_LOG2_DEF,
  localparam int unsigned SW     = $clog2(N_LOG2),
  localparam int unsigned AW     = N_LOG2,
  localparam int unsigned CW     = N_LOG2 - 1
) (
  input  logic [SW-1:0] stage_i,
  input  logic [CW-1:0] cnt_i,
  output logic [AW-1:0] rd_addr_0_o,
  output logic [AW-1:0] rd_addr_1_o,
  output logic [AW-1:0] rd_addr_2_o,
  output logic [CW-1:0] coef_idx_o,
  output logic [AW-1:0] wr_addr_0_o,
  output logic [AW-1:0] wr_addr_1_o
);

  logic [AW-1:0] cx;
  logic [AW-1:0] half;
  logic [AW-1:0] mask;
  logic [AW-1:0] grp;
  logic [AW-1:0] k;
  logic [AW-1:0] mirror;
  logic [SW-1:0] sh;

  // grp = (c >> s) << (s+1) written as a mask so the shift never exceeds the stage width
  always_comb begin
    cx          = {1'b0, cnt_i};
    half        = AW'(1) << stage_i;
    mask        = half - AW'(1);
    k           = cx & mask;
    grp         = (cx & ~mask) << 1;
    mirror      = (half - k) & mask;
    sh          = SW'(N_LOG2 - 1) - stage_i;
    rd_addr_0_o = grp + k;
    rd_addr_1_o = grp + half + k;
    rd_addr_2_o = grp + half + mirror;
    coef_idx_o  = CW'(k << sh);
    wr_addr_0_o = grp + k;
    wr_addr_1_o = grp + half + k;
  end

endmodule

// File: rtl/fht_but_seq.sv
// Stage/op sequencer for the 2-dot Hartley butterfly over ping-pong data banks.
module fht_but_seq import fht_pkg::*; #(
  parameter  int unsigned N_LOG2   = N_LOG2_DEF,
  parameter  int unsigned PIPE_LAT = PIPE_LAT_DEF,
  localparam int unsigned SW       = $clog2(N_LOG2),
  localparam int unsigned AW       = N_LOG2,
  localparam int unsigned CW       = N_LOG2 - 1
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iSTART,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [SW-1:0] oSTAGE,
  output logic          oRD_EN,
  output logic          oRD_BANK,
  output logic [AW-1:0] oRD_ADDR_0,
  output logic [AW-1:0] oRD_ADDR_1,
  output logic [AW-1:0] oRD_ADDR_2,
  output logic [CW-1:0] oCOEF_IDX,
  output logic          oWR_EN,
  output logic          oWR_BANK,
  output logic [AW-1:0] oWR_ADDR_0,
  output logic [AW-1:0] oWR_ADDR_1,
  output logic          oRES_BANK
);

  localparam int unsigned DW = $clog2(PIPE_LAT + 1);
  localparam int unsigned WW = 2 + 2 * AW;

  localparam logic [CW-1:0] CNT_LAST   = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          rd_en_d;

  logic [AW-1:0] ag_rd0, ag_rd1, ag_rd2, ag_wr0, ag_wr1;
  logic [CW-1:0] ag_coef;

  logic [WW-1:0] wr_head_q;
  logic [WW-1:0] wr_dly_q [PIPE_LAT];

  // Addresses are generated for the op about to be registered (next-state side)
  fht_addr_gen #(
    .N_LOG2(N_LOG2)
  ) u_addr_gen (
    .stage_i    (stage_d),
    .cnt_i      (cnt_d),
    .rd_addr_0_o(ag_rd0),
    .rd_addr_1_o(ag_rd1),
    .rd_addr_2_o(ag_rd2),
    .coef_idx_o (ag_coef),
    .wr_addr_0_o(ag_wr0),
    .wr_addr_1_o(ag_wr1)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = RUN;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            cnt_d   = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en_d = (state_d == RUN);

  // Registered read-side outputs plus the write delay line; idle fields are forced to zero
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oSTAGE     <= '0;
      oRD_EN     <= 1'b0;
      oRD_BANK   <= 1'b0;
      oRD_ADDR_0 <= '0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oCOEF_IDX  <= '0;
      wr_head_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wr_dly_q[i] <= '0;
    end else begin
      oBUSY      <= (state_d != IDLE);
      oDONE      <= (state_d == DONE);
      oSTAGE     <= (state_d == IDLE) ? '0 : stage_d;
      oRD_EN     <= rd_en_d;
      oRD_BANK   <= rd_en_d & stage_d[0];
      oRD_ADDR_0 <= rd_en_d ? ag_rd0 : '0;
      oRD_ADDR_1 <= rd_en_d ? ag_rd1 : '0;
      oRD_ADDR_2 <= rd_en_d ? ag_rd2 : '0;
      oCOEF_IDX  <= rd_en_d ? ag_coef : '0;
      wr_head_q  <= rd_en_d ? {1'b1, ~stage_d[0], ag_wr0, ag_wr1} : '0;
      wr_dly_q[0] <= wr_head_q;
      for (int i = 1; i < PIPE_LAT; i++) wr_dly_q[i] <= wr_dly_q[i-1];
    end
  end

  assign {oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} = wr_dly_q[PIPE_LAT-1];
  assign oRES_BANK = 1'(N_LOG2 % 2);

endmodule

// File: tb/tb_fht_but_seq.sv
// Directed bench for fht_but_seq at N_LOG2 = 3 with PIPE_LAT = 2 (main), 1 and 4.
module tb_fht_but_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;

  logic       busy, done, rd_en, rd_bank, wr_en, wr_bank, res_bank;
  logic [1:0] stage, coef;
  logic [2:0] rd0, rd1, rd2, wr0, wr1;

  logic       a_busy, a_done, a_rd_en, a_rd_bank, a_wr_en, a_wr_bank, a_res_bank;
  logic [1:0] a_stage, a_coef;
  logic [2:0] a_rd0, a_rd1, a_rd2, a_wr0, a_wr1;

  logic       b_busy, b_done, b_rd_en, b_rd_bank, b_wr_en, b_wr_bank, b_res_bank;
  logic [1:0] b_stage, b_coef;
  logic [2:0] b_rd0, b_rd1, b_rd2, b_wr0, b_wr1;

  logic [25:0] obs2, obs1, obs4;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived ops for N = 8, index = stage*4 + op
  int rd0_t  [0:11] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int rd1_t  [0:11] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int rd2_t  [0:11] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 7, 6, 5};
  int coef_t [0:11] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  fht_but_seq #(.N_LOG2(3), .PIPE_LAT(2)) u_dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oBUSY(busy), .oDONE(done), .oSTAGE(stage),
    .oRD_EN(rd_en), .oRD_BANK(rd_bank),
    .oRD_ADDR_0(rd0), .oRD_ADDR_1(rd1), .oRD_ADDR_2(rd2), .oCOEF_IDX(coef),
    .oWR_EN(wr_en), .oWR_BANK(wr_bank), .oWR_ADDR_0(wr0), .oWR_ADDR_1(wr1),
    .oRES_BANK(res_bank)
  );

  fht_but_seq #(.N_LOG2(3), .PIPE_LAT(1)) u_dut_pl1 (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oBUSY(a_busy), .oDONE(a_done), .oSTAGE(a_stage),
    .oRD_EN(a_rd_en), .oRD_BANK(a_rd_bank),
    .oRD_ADDR_0(a_rd0), .oRD_ADDR_1(a_rd1), .oRD_ADDR_2(a_rd2), .oCOEF_IDX(a_coef),
    .oWR_EN(a_wr_en), .oWR_BANK(a_wr_bank), .oWR_ADDR_0(a_wr0), .oWR_ADDR_1(a_wr1),
    .oRES_BANK(a_res_bank)
  );

  fht_but_seq #(.N_LOG2(3), .PIPE_LAT(4)) u_dut_pl4 (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oBUSY(b_busy), .oDONE(b_done), .oSTAGE(b_stage),
    .oRD_EN(b_rd_en), .oRD_BANK(b_rd_bank),
    .oRD_ADDR_0(b_rd0), .oRD_ADDR_1(b_rd1), .oRD_ADDR_2(b_rd2), .oCOEF_IDX(b_coef),
    .oWR_EN(b_wr_en), .oWR_BANK(b_wr_bank), .oWR_ADDR_0(b_wr0), .oWR_ADDR_1(b_wr1),
    .oRES_BANK(b_res_bank)
  );

  // Bundle: {busy, done, stage, rd_en, rd_bank, rd0, rd1, rd2, coef, wr_en, wr_bank, wr0, wr1, res_bank}
  assign obs2 = {busy, done, stage, rd_en, rd_bank, rd0, rd1, rd2, coef,
                 wr_en, wr_bank, wr0, wr1, res_bank};
  assign obs1 = {a_busy, a_done, a_stage, a_rd_en, a_rd_bank, a_rd0, a_rd1, a_rd2, a_coef,
                 a_wr_en, a_wr_bank, a_wr0, a_wr1, a_res_bank};
  assign obs4 = {b_busy, b_done, b_stage, b_rd_en, b_rd_bank, b_rd0, b_rd1, b_rd2, b_coef,
                 b_wr_en, b_wr_bank, b_wr0, b_wr1, b_res_bank};

  // Schedule for a start accepted at cycle 0: stage length 4 + pl, DONE at 3*(4+pl)+1
  function automatic void exp_op(input int cyc, input int pl, output logic en,
                                 output logic bsy, output logic dn, output int s, output int c);
    int p, per;
    p = cyc - 1;
    per = 4 + pl;
    en = 1'b0; bsy = 1'b0; dn = 1'b0; s = 0; c = 0;
    if (p >= 0) begin
      if (p < 3 * per) begin
        s = p / per;
        bsy = 1'b1;
        if ((p % per) < 4) begin
          en = 1'b1;
          c = p % per;
        end
      end else if (p == 3 * per) begin
        bsy = 1'b1;
        dn = 1'b1;
        s = 2;
      end
    end
  endfunction

  function automatic logic [25:0] exp_bundle(input int cyc, input int pl);
    logic en, bsy, dn, wen, wbsy, wdn;
    int s, c, ws, wc, i, wi;
    logic [12:0] rd;
    logic [7:0] wr;
    exp_op(cyc, pl, en, bsy, dn, s, c);
    exp_op(cyc - pl, pl, wen, wbsy, wdn, ws, wc);
    i = s * 4 + c;
    wi = ws * 4 + wc;
    rd = en ? {1'b1, 1'(s % 2), 3'(rd0_t[i]), 3'(rd1_t[i]), 3'(rd2_t[i]), 2'(coef_t[i])} : 13'd0;
    wr = wen ? {1'b1, 1'((ws + 1) % 2), 3'(rd0_t[wi]), 3'(rd1_t[wi])} : 8'd0;
    return {bsy, dn, 2'(s), rd, wr, 1'b1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs2[25:1] !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", obs2[25:1]);
    end
    n_cmp++;
    if (res_bank !== 1'b1) begin
      n_err++;
      $display("FAIL reset_res_bank: got %b want 1", res_bank);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Start at cycle 0, optional extra start pulses at cycles pa/pb/pc, check cycles 1..21
  task automatic run_seq(input string tag, input int pa, input int pb, input int pc);
    logic [25:0] e;
    @(posedge clk);
    #1 start = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(posedge clk);
      #1 start = (cyc == pa) || (cyc == pb) || (cyc == pc);
      @(negedge clk);
      e = exp_bundle(cyc, 2);
      n_cmp++;
      if (obs2[25:22] !== e[25:22]) begin
        n_err++;
        $display("FAIL %s ctl cyc %0d: got %h want %h", tag, cyc, obs2[25:22], e[25:22]);
      end
      n_cmp++;
      if (obs2[21:9] !== e[21:9]) begin
        n_err++;
        $display("FAIL %s rd cyc %0d: got %h want %h", tag, cyc, obs2[21:9], e[21:9]);
      end
      n_cmp++;
      if (obs2[8:0] !== e[8:0]) begin
        n_err++;
        $display("FAIL %s wr cyc %0d: got %h want %h", tag, cyc, obs2[8:0], e[8:0]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stage_seq();
    run_seq("stage_seq", -1, -1, -1);
  endtask

  task automatic test_busy_ignore();
    run_seq("busy_ignore", 3, 10, 19);
  endtask

  task automatic test_abort();
    @(posedge clk);
    #1 start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (cyc == 7) rst = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (obs2[21:9] !== {1'b1, 1'b1, 3'd0, 3'd2, 3'd2, 2'd0}) begin
      n_err++;
      $display("FAIL abort_pre rd: got %h want %h", obs2[21:9], {1'b1, 1'b1, 3'd0, 3'd2, 3'd2, 2'd0});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 8; cyc <= 13; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs2 !== 26'd1) begin
        n_err++;
        $display("FAIL abort_quiet cyc %0d: got %h want %h", cyc, obs2, 26'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_restart();
    run_seq("restart", -1, -1, -1);
  endtask

  task automatic test_pipe_lat();
    logic [25:0] e1, e4;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      e1 = exp_bundle(cyc, 1);
      e4 = exp_bundle(cyc, 4);
      n_cmp++;
      if (obs1 !== e1) begin
        n_err++;
        $display("FAIL pipe_lat1 cyc %0d: got %h want %h", cyc, obs1, e1);
      end
      n_cmp++;
      if (obs4 !== e4) begin
        n_err++;
        $display("FAIL pipe_lat4 cyc %0d: got %h want %h", cyc, obs4, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stage_seq();
    test_busy_ignore();
    test_abort();
    test_restart();
    test_pipe_lat();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
